// File: rtl/stream_deser4_pkg.sv
// Shared definitions for the matrix-mult streamers: lane count, counter width
// and the FILL/HOLD state encoding used by both the 4:1 and 1:4 streamers.
package stream_deser4_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/stream_deser4.sv
// 1:4 deserialiser: collects MAC result words into 4-lane groups for RAM
// write-back, with flush of partial groups and one-group backpressure hold.
module stream_deser4
  import stream_deser4_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [2:0]       out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   lane_q [LANES];
  logic [WIDTH-1:0]   lane_d [LANES];
  logic [2:0]         hcnt_q, hcnt_d;
  logic [WIDTH-1:0]   out_q [LANES];
  logic [WIDTH-1:0]   out_d [LANES];
  logic [2:0]         out_cnt_q, out_cnt_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               slot_free;
  logic               close;
  logic [2:0]         n;
  logic [WIDTH-1:0]   grp [LANES];

  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      lane_q      <= '{default: '0};
      hcnt_q      <= '0;
      out_q       <= '{default: '0};
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      hcnt_q      <= hcnt_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    hcnt_d      = hcnt_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    grp         = lane_q;
    n           = '0;
    close       = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept) grp[cnt_q] = in_data;
        n     = {1'b0, cnt_q} + {2'b00, accept};
        // A 4th accept closes the group regardless of flush; n=0 flush is dropped.
        close = (accept && cnt_q == CNT_W'(LANES - 1)) || (flush && n != 3'd0);
        if (close) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (i >= 32'(n)) grp[i] = '0;
          end
          cnt_d = '0;
          if (slot_free) begin
            out_d       = grp;
            out_cnt_d   = n;
            out_valid_d = 1'b1;
          end else begin
            lane_d  = grp;
            hcnt_d  = n;
            state_d = ST_HOLD;
          end
        end else if (accept) begin
          lane_d[cnt_q] = in_data;
          cnt_d         = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_d       = lane_q;
          out_cnt_d   = hcnt_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_FILL);
  end

  assign out_0     = out_q[0];
  assign out_1     = out_q[1];
  assign out_2     = out_q[2];
  assign out_3     = out_q[3];
  assign out_count = out_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_deser4.sv
// Directed and randomised checks of the 1:4 result deserialiser.
module tb_stream_deser4;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out_0, out_1, out_2, out_3;
  logic [2:0]       out_count;
  logic             out_valid;
  logic             out_ready;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  stream_deser4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_0     (out_0),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic check_group(input string tag, input logic [2:0] cnt,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_l0"}, 32'(out_0), 32'(e0));
    check({tag, "_l1"}, 32'(out_1), 32'(e1));
    check({tag, "_l2"}, 32'(out_2), 32'(e2));
    check({tag, "_l3"}, 32'(out_3), 32'(e3));
  endtask

  task automatic feed(input logic [15:0] w);
    in_valid = 1'b1; in_data = w;
    step();
    in_valid = 1'b0;
  endtask

  logic [15:0] expq[$];
  logic [15:0] lanes [4];

  initial begin
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_out0", 32'(out_0), 32'd0);

    // back-to-back groups with a free consumer
    out_ready = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      feed(16'(w));
      if (w == 3) check("b2b_pre_valid", 32'(out_valid), 32'd0);
      if (w == 4) check_group("b2b_g1", 3'd4, 16'd1, 16'd2, 16'd3, 16'd4);
      if (w == 5) check("b2b_consumed", 32'(out_valid), 32'd0);
      if (w == 8) check_group("b2b_g2", 3'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    end
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // backpressure: second group parks in HOLD; a flush there is ignored
    do_reset();
    out_ready = 1'b0;
    for (int w = 1; w <= 8; w++) begin
      feed(16'(w));
      if (w == 4) check_group("bp_g1", 3'd4, 16'd1, 16'd2, 16'd3, 16'd4);
    end
    check("bp_in_ready_hold", 32'(in_ready), 32'd0);
    check("bp_stable_l0", 32'(out_0), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("bp_still_hold", 32'(in_ready), 32'd0);
    check_group("bp_g1_stable", 3'd4, 16'd1, 16'd2, 16'd3, 16'd4);
    out_ready = 1'b1;
    step();
    check_group("bp_g2", 3'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // flush of a partial group, then a flush with nothing collected
    do_reset();
    out_ready = 1'b1;
    feed(16'h000A);
    feed(16'h000B);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_group("fl_g", 3'd2, 16'h000A, 16'h000B, 16'h0, 16'h0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_empty_valid", 32'(out_valid), 32'd0);
    for (int w = 1; w <= 4; w++) feed(16'(w + 16'h20));
    check_group("fl_after", 3'd4, 16'h21, 16'h22, 16'h23, 16'h24);

    // flush coinciding with the 3rd accept
    do_reset();
    out_ready = 1'b1;
    feed(16'h0001);
    feed(16'h0002);
    flush = 1'b1;
    feed(16'h000C);
    flush = 1'b0;
    check_group("fla_g", 3'd3, 16'h1, 16'h2, 16'hC, 16'h0);

    // reset in the middle of a group leaves no residue
    do_reset();
    out_ready = 1'b1;
    feed(16'h0011);
    feed(16'h0022);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_valid", 32'(out_valid), 32'd0);
    for (int w = 1; w <= 4; w++) feed(16'(w + 16'h30));
    check_group("mr_g", 3'd4, 16'h31, 16'h32, 16'h33, 16'h34);

    // random flow control and flushes against an order scoreboard
    do_reset();
    begin
      int unsigned sent = 0;
      int unsigned cyc = 0;
      logic [15:0] seq = 16'd0;
      while ((sent < 10000 || expq.size() != 0) && cyc < 80000) begin
        cyc++;
        in_valid  = (sent < 10000) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
        out_ready = (sent < 10000) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        flush     = (sent < 10000) ? 1'($urandom_range(0, 15) == 0) : 1'b1;
        in_data   = seq;
        if (out_valid && out_ready) begin
          lanes[0] = out_0; lanes[1] = out_1; lanes[2] = out_2; lanes[3] = out_3;
          if (out_count == 3'd0 || out_count > 3'd4)
            check("rnd_count_range", 32'(out_count), 32'd4);
          for (int i = 0; i < 4; i++) begin
            if (i < int'(out_count)) begin
              if (expq.size() == 0) check("rnd_extra_word", 32'(lanes[i]), 32'hFFFF_FFFF);
              else check("rnd_word", 32'(lanes[i]), 32'(expq.pop_front()));
            end else begin
              check("rnd_pad_zero", 32'(lanes[i]), 32'd0);
            end
          end
        end
        if (in_valid && in_ready) begin
          expq.push_back(seq);
          seq++;
          sent++;
        end
        step();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      check("rnd_all_sent", sent, 32'd10000);
      check("rnd_queue_empty", 32'(expq.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
